// File: rtl/rib_arbiter_pkg.sv
// rtl/rib_arbiter_pkg.sv - shared state encodings, master indices and defaults for the register-bus arbiter
package rib_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] CORE = 2'd0;
    localparam logic [1:0] JTAG = 2'd1;
    localparam logic [1:0] UART = 2'd2;

    localparam int DEFAULT_TIMEOUT = 255;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= UART) ? CORE : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rib_arbiter_if.sv
// rtl/rib_arbiter_if.sv - master-side and slave-side bus signals of the register-bus arbiter
interface rib_arbiter_if;
    logic [2:0]  m_req;
    logic [2:0]  m_we;
    logic [95:0] m_addr;
    logic [95:0] m_wdata;
    logic [31:0] m_rdata;
    logic [2:0]  m_ack;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_ack;
    logic        hold_core;
    logic        err;

    modport master (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        output m_rdata, m_ack, s_req, s_we, s_addr, s_wdata, hold_core, err
    );

    modport slave (
        output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        input  m_rdata, m_ack, s_req, s_we, s_addr, s_wdata, hold_core, err
    );
endinterface

// File: rtl/rib_arb_pick.sv
// rtl/rib_arb_pick.sv - combinational winner search starting one past the last owner
module rib_arb_pick
    import rib_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_owner_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);
    logic [1:0] cand;

    always_comb begin
        idx_o   = CORE;
        valid_o = 1'b0;
        cand    = next_idx(last_owner_i);
        for (int k = 0; k < 3; k++) begin
            if (!valid_o && req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
            cand = next_idx(cand);
        end
    end
endmodule

// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - three-master register-bus arbiter with slave timeout; RIB_ARB_ROUND_ROBIN_EN selects rotating priority
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input logic           clk,
    input logic           rst,
    rib_arbiter_if.master bus
);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  last_owner;
    logic [1:0]  pick_idx;
    logic        pick_valid;
    logic        in_access;
    logic        in_done;

`ifdef RIB_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;
    assign last_owner = last_q;
`else
    // jtag > uart > core is exactly the rotation seen from a permanent core owner
    assign last_owner = CORE;
`endif

    rib_arb_pick u_pick (
        .req_i        (bus.m_req),
        .last_owner_i (last_owner),
        .idx_o        (pick_idx),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef RIB_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    we_d    = bus.m_we[pick_idx];
                    addr_d  = bus.m_addr[{pick_idx, 5'd0} +: 32];
                    wdata_d = bus.m_wdata[{pick_idx, 5'd0} +: 32];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCESS;
`ifdef RIB_ARB_ROUND_ROBIN_EN
                    last_d  = pick_idx;
`endif
                end
            end
            ST_ACCESS: begin
                // a slave ack in the timeout cycle still completes normally
                if (bus.s_ack) begin
                    rdata_d = we_q ? '0 : bus.s_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef RIB_ARB_ROUND_ROBIN_EN
            last_q  <= CORE;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef RIB_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign in_access     = (state_q == ST_ACCESS);
    assign in_done       = (state_q == ST_DONE);
    assign bus.s_req     = in_access;
    assign bus.s_we      = in_access & we_q;
    assign bus.s_addr    = in_access ? addr_q : '0;
    assign bus.s_wdata   = in_access ? wdata_q : '0;
    assign bus.m_ack     = in_done ? (3'b001 << owner_q) : 3'b000;
    assign bus.m_rdata   = in_done ? rdata_q : '0;
    assign bus.err       = in_done & err_q;
    assign bus.hold_core = (state_q != ST_IDLE) && (owner_q != CORE);
endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - self-checking bench for rib_arbiter against a transaction-level model
module tb_rib_arbiter;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rib_arbiter_if bus ();

    rib_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    int ack_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // slave responder: acks after slave_lat waiting cycles, never when slave_lat < 0
    int          slave_lat  = 0;
    logic [31:0] slave_data = 32'h0;
    bit          stray      = 1'b0;
    int          acc_n      = 0;

    always @(posedge clk) begin
        #1;
        if (bus.s_req === 1'b1) begin
            bus.s_ack   = (slave_lat >= 0) && (acc_n == slave_lat);
            bus.s_rdata = slave_data;
            acc_n++;
        end else begin
            acc_n       = 0;
            bus.s_ack   = stray;
            bus.s_rdata = 32'h0BAD_F00D;
        end
    end

    // transaction-level reference model, checked every cycle once reset has taken effect
    bit          mv = 0, mdone = 0, mwe = 0, merr = 0, clean = 1;
    int          mown = 0, mwait = 0;
    logic [31:0] maddr = 0, mwd = 0, mres = 0;
`ifdef RIB_ARB_ROUND_ROBIN_EN
    int          mlast = 0;
`endif

    function automatic int winner(input logic [2:0] r, input int first);
        for (int k = 0; k < 3; k++)
            if (r[(first + k) % 3]) return (first + k) % 3;
        return -1;
    endfunction

    always @(negedge clk) begin
        bit e_sreq;
        int w;
        int first;
        if (started) begin
            e_sreq = mv && !mdone;
            check("s_req", bus.s_req, e_sreq);
            check("m_ack", bus.m_ack, mdone ? (32'd1 << mown) : 32'd0);
            check("err", bus.err, mdone && merr);
            check("hold_core", bus.hold_core, mv && (mown != 0));
            if (e_sreq) begin
                check("s_we", bus.s_we, mwe);
                check("s_addr", bus.s_addr, maddr);
                check("s_wdata", bus.s_wdata, mwd);
            end
            if (mdone) check("m_rdata", bus.m_rdata, mres);
            if (clean) begin
                check("clean_s_addr", bus.s_addr, 0);
                check("clean_s_wdata", bus.s_wdata, 0);
                check("clean_m_rdata", bus.m_rdata, 0);
            end
            if (bus.m_ack != 3'b000) ack_count++;
        end
        if (rst) begin
            mv = 0; mdone = 0; clean = 1;
`ifdef RIB_ARB_ROUND_ROBIN_EN
            mlast = 0;
`endif
        end else if (mdone) begin
            mv = 0; mdone = 0;
        end else if (mv) begin
            if (bus.s_ack) begin
                mres = mwe ? 32'd0 : bus.s_rdata; merr = 0; mdone = 1;
            end else if (mwait == TIMEOUT - 1) begin
                mres = 0; merr = 1; mdone = 1;
            end else begin
                mwait++;
            end
        end else begin
`ifdef RIB_ARB_ROUND_ROBIN_EN
            first = (mlast + 1) % 3;
`else
            first = 1;
`endif
            w = winner(bus.m_req, first);
            if (w >= 0) begin
                mv = 1; mown = w; mwait = 0; clean = 0;
                mwe   = bus.m_we[w];
                maddr = bus.m_addr[w*32 +: 32];
                mwd   = bus.m_wdata[w*32 +: 32];
`ifdef RIB_ARB_ROUND_ROBIN_EN
                mlast = w;
`endif
            end
        end
    end

    bit keep_req = 1'b0;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.m_we[i]          = we;
        bus.m_addr[i*32 +: 32]  = addr;
        bus.m_wdata[i*32 +: 32] = wd;
    endtask

    task automatic wait_ack(output int n, output logic [2:0] a, output logic [31:0] d,
                            output logic e, output int nsreq, output logic hold_any);
        n = -1; a = 0; d = 0; e = 0; nsreq = 0; hold_any = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_req) nsreq++;
            if (bus.hold_core) hold_any = 1;
            if (bus.m_ack != 3'b000) begin
                n = i; a = bus.m_ack; d = bus.m_rdata; e = bus.err;
                if (!keep_req) bus.m_req = bus.m_req & ~bus.m_ack;
                return;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ns, acks0;
        logic [2:0] a;
        logic [31:0] d;
        logic e, h;
        int exp_order[$];
        int got;

        bus.m_req = 0; bus.m_we = 0; bus.m_addr = 0; bus.m_wdata = 0;
        bus.s_ack = 0; bus.s_rdata = 0;
        repeat (2) @(posedge clk);
        #1 started = 1;
        @(negedge clk);
        check("rst_s_req", bus.s_req, 0);
        check("rst_m_ack", bus.m_ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_hold", bus.hold_core, 0);
        check("rst_s_we", bus.s_we, 0);
        @(posedge clk); #1 rst = 0;
        idle(2);

        // core read, slave acks immediately
        slave_lat = 0; slave_data = 32'hDEADBEEF;
        set_master(0, 0, 32'h0000_0100, 32'h0);
        bus.m_req = 3'b001;
        wait_ack(n, a, d, e, ns, h);
        check("t1_latency", n, 2);
        check("t1_ack", a, 3'b001);
        check("t1_rdata", d, 32'hDEADBEEF);
        check("t1_sreq_cycles", ns, 1);
        check("t1_hold", h, 0);
        idle(3);

        // jtag and core together: jtag first under fixed priority
        slave_lat = 1; slave_data = 32'hA5A5_0001;
        set_master(1, 0, 32'h0000_1000, 32'h0);
        set_master(0, 1, 32'h0000_0200, 32'h1234_5678);
        bus.m_req = 3'b011;
        wait_ack(n, a, d, e, ns, h);
`ifndef RIB_ARB_ROUND_ROBIN_EN
        check("t2_first_ack", a, 3'b010);
        check("t2_first_rdata", d, 32'hA5A5_0001);
        check("t2_first_hold", h, 1);
        check("t2_first_latency", n, 3);
        wait_ack(n, a, d, e, ns, h);
        check("t2_second_ack", a, 3'b001);
        check("t2_second_rdata", d, 0);
        check("t2_second_hold", h, 0);
`else
        wait_ack(n, a, d, e, ns, h);
`endif
        idle(3);

        // slave never acks: timeout after TIMEOUT access cycles
        slave_lat = -1;
        set_master(0, 0, 32'h0000_0400, 32'h0);
        bus.m_req = 3'b001;
        wait_ack(n, a, d, e, ns, h);
        check("t3_ack", a, 3'b001);
        check("t3_err", e, 1);
        check("t3_rdata", d, 0);
        check("t3_sreq_cycles", ns, TIMEOUT);
        check("t3_latency", n, TIMEOUT + 1);
        idle(3);

        // ack in the timeout cycle wins
        slave_lat = TIMEOUT - 1; slave_data = 32'hC0FF_EE00;
        bus.m_req = 3'b001;
        wait_ack(n, a, d, e, ns, h);
        check("t4_err", e, 0);
        check("t4_rdata", d, 32'hC0FF_EE00);
        check("t4_sreq_cycles", ns, TIMEOUT);
        idle(3);

        // owner drops its request mid-access
        slave_lat = 2;
        set_master(1, 1, 32'h0000_0800, 32'h0000_FACE);
        bus.m_req = 3'b010;
        @(posedge clk); #1 bus.m_req = 3'b000;
        wait_ack(n, a, d, e, ns, h);
        check("t5_ack", a, 3'b010);
        check("t5_rdata", d, 0);
        check("t5_latency", n, 3);
        idle(3);

        // reset in the second access cycle of a uart write
        acks0 = ack_count;
        slave_lat = -1;
        set_master(2, 1, 32'h0000_3000, 32'h0000_55AA);
        bus.m_req = 3'b100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; bus.m_req = 3'b000;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("t6_s_req", bus.s_req, 0);
        check("t6_m_ack", bus.m_ack, 0);
        check("t6_hold", bus.hold_core, 0);
        check("t6_s_addr", bus.s_addr, 0);
        check("t6_no_ack", ack_count, acks0);
        idle(1);
        slave_lat = 0; slave_data = 32'h600D_0001;
        set_master(0, 0, 32'h0000_0010, 32'h0);
        bus.m_req = 3'b001;
        wait_ack(n, a, d, e, ns, h);
        check("t6_after_ack", a, 3'b001);
        check("t6_after_rdata", d, 32'h600D_0001);
        check("t6_after_latency", n, 2);
        idle(3);

        // stray slave ack while idle is ignored
        acks0 = ack_count;
        stray = 1;
        idle(4);
        stray = 0;
        idle(2);
        check("t7_stray_no_ack", ack_count, acks0);

        // all three masters requesting
        slave_lat = 0; slave_data = 32'h1111_2222;
        set_master(0, 0, 32'h0000_0A00, 32'h0);
        set_master(1, 0, 32'h0000_0B00, 32'h0);
        set_master(2, 0, 32'h0000_0C00, 32'h0);
`ifdef RIB_ARB_ROUND_ROBIN_EN
        keep_req = 1;
        exp_order = '{1, 2, 0, 1, 2, 0};
`else
        exp_order = '{1, 2, 0};
`endif
        bus.m_req = 3'b111;
        foreach (exp_order[i]) begin
            wait_ack(n, a, d, e, ns, h);
            got = a[1] ? 1 : (a[2] ? 2 : (a[0] ? 0 : -1));
            check("t8_grant_order", got, exp_order[i]);
        end
        @(posedge clk); #1;
        keep_req = 0; bus.m_req = 3'b000;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rib_arbiter.md
RIB_ARBITER -- requirements
Module: rib_arbiter

Interface
REQ-001 TIMEOUT_CYCLES, 255: slave-ack wait limit in cycles (legal range 2..65535).
REQ-002 clk  in  1  the block's single clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 m_req  in  3  per-master request: bit0 core, bit1 jtag, bit2 uart_debug; SHALL be held until that master's m_ack.
REQ-005 m_we  in  3  per-master write enable.
REQ-006 m_addr  in  96  per-master address; master i SHALL occupy bits [32i+31:32i].
REQ-007 m_wdata  in  96  per-master write data, same packing as m_addr.
REQ-008 m_rdata  out  32  shared read data; SHALL be valid only with m_ack.
REQ-009 m_ack  out  3  one-hot completion pulse, one cycle wide.
REQ-010 s_req, s_we  out  1 each  slave-side request and write enable.
REQ-011 s_addr, s_wdata  out  32 each  slave-side address and write data.
REQ-012 s_rdata  in  32  slave read data.
REQ-013 s_ack  in  1  slave completion.
REQ-014 hold_core  out  1  pipeline hold to the core.
REQ-015 err  out  1  timeout pulse.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, ACCESS and DONE.
REQ-017 IDLE, any m_req set -> the block SHALL latch the winner index and its we/addr/wdata, then enter ACCESS; no request -> SHALL stay in IDLE.
REQ-018 ACCESS: s_req=1 and s_we/s_addr/s_wdata SHALL come from the latched values; first s_req SHALL be in the cycle after the winning request was sampled.
REQ-019 ACCESS with s_ack=1 -> m_rdata SHALL be registered from s_rdata (0 on writes), then the block SHALL enter DONE.
REQ-020 DONE SHALL last one cycle: m_ack[owner]=1, s_req=0, m_req not sampled; then IDLE.
REQ-021 Minimum transaction: a slave that acks in its first ACCESS cycle SHALL give m_ack 2 cycles after m_req is sampled.
REQ-022 The wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without s_ack.
REQ-023 Counter reaching TIMEOUT_CYCLES-1 without s_ack -> m_rdata=0, err SHALL pulse with m_ack in DONE, and the transaction SHALL be aborted.
REQ-024 s_ack in the same cycle as the timeout -> the ack SHALL win and err SHALL stay 0.
REQ-025 The owner's m_req dropping mid-ACCESS SHALL NOT abort the transaction; m_ack SHALL still pulse.
REQ-026 s_ack outside ACCESS SHALL be ignored.
REQ-027 hold_core SHALL be 1 when state != IDLE and owner != core, and 0 otherwise.
REQ-028 hold_core SHALL be driven only from registered state.

Reset
REQ-029 rst=1 at any clock edge SHALL force IDLE, including mid-ACCESS, dropping any outstanding transaction with no m_ack.
REQ-030 During and after reset, s_req, s_we, s_addr, s_wdata, m_rdata, m_ack, err, hold_core and the counter SHALL all be 0.
REQ-031 Reset SHALL set the last-owner register to core (0).

Configuration
REQ-032 With RIB_ARB_ROUND_ROBIN_EN defined, priority SHALL rotate: the search SHALL start at last_owner+1 modulo 3.
REQ-033 The last-owner register SHALL update on every grant when RIB_ARB_ROUND_ROBIN_EN is defined.
REQ-034 Without RIB_ARB_ROUND_ROBIN_EN, priority SHALL be fixed jtag > uart_debug > core, and the last-owner register SHALL be absent.

Structure
REQ-035 The shared defines package SHALL hold the state encodings, the master index constants (CORE=0, JTAG=1, UART=2) and the default timeout.
REQ-036 Winner selection SHALL live in one sub-module, rib_arb_pick, which is purely combinational: m_req and last_owner in, index and valid out.

Verification
REQ-037 Core-only read at 0x0000_0100, slave acks on the first ACCESS cycle with 0xDEADBEEF -> s_req for 1 cycle, m_ack[0] 2 cycles after the request is sampled, m_rdata=0xDEADBEEF, hold_core=0 throughout.
REQ-038 Jtag and core request together, fixed priority -> jtag served first with hold_core=1 during its ACCESS/DONE, then the core is served.
REQ-039 RIB_ARB_ROUND_ROBIN_EN defined, all three requesting continuously -> grant order 1,2,0,1,2,0.
REQ-040 Slave never acks, TIMEOUT_CYCLES=4 -> 4 ACCESS cycles, then err=1 with m_ack for one cycle, m_rdata=0, then IDLE.
REQ-041 rst asserted in the second ACCESS cycle of a uart write -> next cycle IDLE, all outputs 0, no m_ack; a following core request is served normally.
